// File: rtl/v_relu_requant.sv
// v_relu_requant: ReLU + fixed-point rescale + saturation stage after the vector MAC.
// Pulls MAC results chunk-wise from an upstream v_fifo and pushes requantised chunks
// to a downstream v_fifo, one chunk per READ -> WAIT -> WRITE pass.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_in           synchronous active-low reset
//   in_data_ready    upstream FIFO holds at least one chunk
//   in_data          upstream chunk, valid the cycle after req_chunk_in
//   req_chunk_in     read strobe to upstream FIFO (combinational)
//   out_ready        downstream FIFO can accept a chunk
//   write_out_data   registered result chunk
//   req_chunk_out    write strobe to downstream FIFO (combinational)
//   out_vector_valid high with the write of the last chunk of a vector
module v_relu_requant #(
   parameter int unsigned InVecLength = 11,
   parameter int unsigned WorkingRegs = 11,
   parameter int unsigned NBits       = 8,
   parameter int unsigned ScaleMult   = 1,
   parameter int unsigned Shift       = 0
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                in_data_ready,
   input  logic [WorkingRegs-1:0][NBits-1:0]   in_data,
   output logic                                req_chunk_in,
   input  logic                                out_ready,
   output logic [WorkingRegs-1:0][NBits-1:0]   write_out_data,
   output logic                                req_chunk_out,
   output logic                                out_vector_valid
);

   localparam int unsigned NumChunks = InVecLength / WorkingRegs;
   localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam int unsigned ProdW     = 2 * NBits;
   // One extra bit so the rounding add can never wrap.
   localparam int unsigned SumW      = ProdW + 1;

   localparam logic [NBits-1:0] ScaleW    = NBits'(ScaleMult);
   localparam logic [CntW-1:0]  LastChunk = CntW'(NumChunks - 1);
   localparam logic [SumW-1:0]  MaxPos    = SumW'((64'd1 << (NBits - 1)) - 64'd1);
   // Half an LSB of the shifted result; evaluates to zero when Shift is zero.
   localparam logic [SumW-1:0]  RoundBias = SumW'((64'd1 << Shift) >> 1);

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                            state;
   state_t                            state_nxt;
   logic [CntW-1:0]                   cnt;
   logic [CntW-1:0]                   cnt_nxt;
   logic                              load;
   logic [WorkingRegs-1:0][NBits-1:0] proc_data;

   // ReLU, multiply, round-half-up shift, clamp to the largest positive value.
   function automatic logic [NBits-1:0] requant(input logic [NBits-1:0] x);
      logic [ProdW-1:0] r;
      logic [ProdW-1:0] p;
      logic [SumW-1:0]  q;
      r = x[NBits-1] ? '0 : ProdW'(x);
      p = r * ProdW'(ScaleW);
      q = (SumW'(p) + RoundBias) >> Shift;
      if (q > MaxPos) begin
         return NBits'(MaxPos);
      end
      return NBits'(q);
   endfunction

   // Element-wise datapath on the incoming chunk.
   always_comb begin
      proc_data = '0;
      for (int i = 0; i < int'(WorkingRegs); i++) begin
         proc_data[i] = requant(in_data[i]);
      end
   end

   // State, chunk counter and result register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= S_READ;
         cnt            <= '0;
         write_out_data <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (load) begin
            write_out_data <= proc_data;
         end
      end
   end

   // Next state and FIFO strobes; strobes are forced low while reset is held.
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      load             = 1'b0;
      req_chunk_in     = 1'b0;
      req_chunk_out    = 1'b0;
      out_vector_valid = 1'b0;

      case (state)
         S_READ: begin
            req_chunk_in = in_data_ready;
            if (in_data_ready) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            load      = 1'b1;
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            req_chunk_out = out_ready;
            if (out_ready) begin
               state_nxt = S_READ;
               if (cnt == LastChunk) begin
                  out_vector_valid = 1'b1;
                  cnt_nxt          = '0;
               end else begin
                  cnt_nxt = cnt + CntW'(1);
               end
            end
         end
         default: begin
            state_nxt = S_READ;
         end
      endcase

      if (!rst_in) begin
         req_chunk_in     = 1'b0;
         req_chunk_out    = 1'b0;
         out_vector_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_v_relu_requant.sv
// Directed bench for v_relu_requant: three instances cover the default 11-element
// single-chunk config, a rescaled config, and an 8-element two-chunk config.
module tb_v_relu_requant;

   logic clk;
   int   errors;
   int   checks;

   // Default instance: 11 elements, one chunk, identity scale.
   logic                d_rst, d_rdy, d_ordy, d_req_in, d_req_out, d_ovv;
   logic [10:0][7:0]    d_in, d_out;
   // Rescale instance: 4 elements, one chunk, x*3 >> 1 with rounding.
   logic                s_rst, s_rdy, s_ordy, s_req_in, s_req_out, s_ovv;
   logic [3:0][7:0]     s_in, s_out;
   // Two-chunk instance: 8 elements in chunks of 4.
   logic                t_rst, t_rdy, t_ordy, t_req_in, t_req_out, t_ovv;
   logic [3:0][7:0]     t_in, t_out;

   v_relu_requant u_def (
      .clk_in(clk), .rst_in(d_rst), .in_data_ready(d_rdy), .in_data(d_in),
      .req_chunk_in(d_req_in), .out_ready(d_ordy), .write_out_data(d_out),
      .req_chunk_out(d_req_out), .out_vector_valid(d_ovv)
   );

   v_relu_requant #(.InVecLength(4), .WorkingRegs(4), .NBits(8), .ScaleMult(3), .Shift(1)) u_sc (
      .clk_in(clk), .rst_in(s_rst), .in_data_ready(s_rdy), .in_data(s_in),
      .req_chunk_in(s_req_in), .out_ready(s_ordy), .write_out_data(s_out),
      .req_chunk_out(s_req_out), .out_vector_valid(s_ovv)
   );

   v_relu_requant #(.InVecLength(8), .WorkingRegs(4)) u_two (
      .clk_in(clk), .rst_in(t_rst), .in_data_ready(t_rdy), .in_data(t_in),
      .req_chunk_in(t_req_in), .out_ready(t_ordy), .write_out_data(t_out),
      .req_chunk_out(t_req_out), .out_vector_valid(t_ovv)
   );

   // Chunks for the two-chunk instance and their identity-scale results.
   localparam logic [3:0][7:0] Chunk0 = {8'd127, 8'd30, 8'hEC, 8'd10};  // {10,-20,30,127}
   localparam logic [3:0][7:0] Exp0   = {8'd127, 8'd30, 8'd0,  8'd10};
   localparam logic [3:0][7:0] Chunk1 = {8'hFF, 8'd64, 8'd5, 8'h80};    // {-128,5,64,-1}
   localparam logic [3:0][7:0] Exp1   = {8'd0,  8'd64, 8'd5, 8'd0};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      d_rst = 0; s_rst = 0; t_rst = 0;
      d_rdy = 1; s_rdy = 1; t_rdy = 1;
      d_ordy = 1; s_ordy = 1; t_ordy = 1;
      d_in = {11{8'h55}}; s_in = {4{8'h55}}; t_in = {4{8'h55}};
      step();
      step();
      checks++; if (d_req_in !== 1'b0) begin errors++; $display("FAIL reset_d_req_in got=%b want=0", d_req_in); end
      checks++; if (d_req_out !== 1'b0) begin errors++; $display("FAIL reset_d_req_out got=%b want=0", d_req_out); end
      checks++; if (d_ovv !== 1'b0) begin errors++; $display("FAIL reset_d_ovv got=%b want=0", d_ovv); end
      checks++; if (d_out !== '0) begin errors++; $display("FAIL reset_d_data got=%h want=0", d_out); end
      checks++; if (s_req_in !== 1'b0 || s_out !== '0) begin errors++; $display("FAIL reset_s got req_in=%b data=%h want 0/0", s_req_in, s_out); end
      checks++; if (t_req_in !== 1'b0 || t_out !== '0) begin errors++; $display("FAIL reset_t got req_in=%b data=%h want 0/0", t_req_in, t_out); end
      d_rst = 1; s_rst = 1; t_rst = 1;
      d_rdy = 0; s_rdy = 0; t_rdy = 0;
      step();
   endtask

   task automatic test_default();
      int vi[11];
      int ve[11];
      logic [10:0][7:0] xin, xexp;
      vi = '{-5, 0, 1, 100, 127, -128, 2, 3, 4, 5, 6};
      ve = '{0, 0, 1, 100, 127, 0, 2, 3, 4, 5, 6};
      for (int i = 0; i < 11; i++) begin
         xin[i]  = 8'(vi[i]);
         xexp[i] = 8'(ve[i]);
      end
      d_rdy = 1; d_ordy = 1; #1;
      checks++; if (d_req_in !== 1'b1 || d_req_out !== 1'b0) begin errors++; $display("FAIL default_read got req_in=%b req_out=%b want 1/0", d_req_in, d_req_out); end
      step();
      d_in = xin; #1;
      checks++; if (d_req_in !== 1'b0 || d_req_out !== 1'b0) begin errors++; $display("FAIL default_wait got req_in=%b req_out=%b want 0/0", d_req_in, d_req_out); end
      step();
      d_in = {11{8'h55}}; #1;
      checks++; if (d_req_out !== 1'b1) begin errors++; $display("FAIL default_latency got req_out=%b want=1", d_req_out); end
      checks++; if (d_ovv !== 1'b1) begin errors++; $display("FAIL default_ovv got=%b want=1", d_ovv); end
      checks++; if (d_out !== xexp) begin errors++; $display("FAIL default_data got=%h want=%h", d_out, xexp); end
      checks++; if (d_req_in !== 1'b0) begin errors++; $display("FAIL default_no_overlap got req_in=%b want=0", d_req_in); end
      step();
      d_rdy = 0; #1;
      checks++; if (d_req_out !== 1'b0 || d_out !== xexp) begin errors++; $display("FAIL default_after got req_out=%b data=%h want 0/%h", d_req_out, d_out, xexp); end
   endtask

   task automatic test_scale();
      logic [3:0][7:0] xexp;
      xexp = {8'd0, 8'd127, 8'd2, 8'd75};        // 50->75, 1->2, 100->127, -1->0
      s_rdy = 1; s_ordy = 1; #1;
      checks++; if (s_req_in !== 1'b1) begin errors++; $display("FAIL scale_read got=%b want=1", s_req_in); end
      step();
      s_rdy = 0; s_in = {8'hFF, 8'd100, 8'd1, 8'd50}; #1;
      step();
      s_in = {4{8'h55}}; #1;
      checks++; if (s_req_out !== 1'b1 || s_ovv !== 1'b1) begin errors++; $display("FAIL scale_write got req_out=%b ovv=%b want 1/1", s_req_out, s_ovv); end
      checks++; if (s_out !== xexp) begin errors++; $display("FAIL scale_data got=%h want=%h", s_out, xexp); end
      step();
   endtask

   task automatic test_back_to_back();
      logic exp_in[6];
      logic exp_out[6];
      logic exp_ovv[6];
      exp_in  = '{1, 0, 0, 1, 0, 0};
      exp_out = '{0, 0, 1, 0, 0, 1};
      exp_ovv = '{0, 0, 0, 0, 0, 1};
      for (int c = 0; c < 6; c++) begin
         t_rdy = 1; t_ordy = 1;
         t_in  = (c == 1) ? Chunk0 : (c == 4) ? Chunk1 : {4{8'h55}};
         #1;
         checks++; if (t_req_in !== exp_in[c] || t_req_out !== exp_out[c] || t_ovv !== exp_ovv[c]) begin
            errors++;
            $display("FAIL b2b_cycle%0d got req_in=%b req_out=%b ovv=%b want %b/%b/%b", c, t_req_in, t_req_out, t_ovv, exp_in[c], exp_out[c], exp_ovv[c]);
         end
         if (c == 2) begin
            checks++; if (t_out !== Exp0) begin errors++; $display("FAIL b2b_data0 got=%h want=%h", t_out, Exp0); end
         end
         if (c == 5) begin
            checks++; if (t_out !== Exp1) begin errors++; $display("FAIL b2b_data1 got=%h want=%h", t_out, Exp1); end
         end
         step();
      end
      t_rdy = 0; #1;
      checks++; if (t_req_in !== 1'b0 || t_req_out !== 1'b0) begin errors++; $display("FAIL b2b_idle got req_in=%b req_out=%b want 0/0", t_req_in, t_req_out); end
   endtask

   task automatic test_stall();
      t_rdy = 1; t_ordy = 0; #1;
      step();
      t_in = Chunk0; #1;
      step();
      for (int c = 0; c < 5; c++) begin
         t_in = {4{8'h11}}; t_rdy = 1; t_ordy = 0; #1;
         checks++; if (t_req_out !== 1'b0 || t_req_in !== 1'b0 || t_out !== Exp0) begin
            errors++;
            $display("FAIL stall_cycle%0d got req_out=%b req_in=%b data=%h want 0/0/%h", c, t_req_out, t_req_in, t_out, Exp0);
         end
         step();
      end
      t_ordy = 1; #1;
      checks++; if (t_req_out !== 1'b1 || t_ovv !== 1'b0 || t_req_in !== 1'b0) begin errors++; $display("FAIL stall_release got req_out=%b ovv=%b req_in=%b want 1/0/0", t_req_out, t_ovv, t_req_in); end
      step();
      t_rdy = 1; #1;
      checks++; if (t_req_out !== 1'b0 || t_req_in !== 1'b1) begin errors++; $display("FAIL stall_single_write got req_out=%b req_in=%b want 0/1", t_req_out, t_req_in); end
      step();
      t_rdy = 0; t_in = Chunk1; #1;
      step();
      #1;
      checks++; if (t_req_out !== 1'b1 || t_ovv !== 1'b1 || t_out !== Exp1) begin errors++; $display("FAIL stall_chunk1 got req_out=%b ovv=%b data=%h want 1/1/%h", t_req_out, t_ovv, t_out, Exp1); end
      step();
   endtask

   task automatic test_reset_mid();
      t_rdy = 1; t_ordy = 1; #1;
      step();
      t_rdy = 0; t_in = Chunk0; #1;
      step();
      #1;
      checks++; if (t_req_out !== 1'b1 || t_ovv !== 1'b0) begin errors++; $display("FAIL rmid_chunk0 got req_out=%b ovv=%b want 1/0", t_req_out, t_ovv); end
      step();
      t_rdy = 1; #1;
      step();
      t_rdy = 0; t_rst = 0; t_in = Chunk1; #1;
      checks++; if (t_req_in !== 1'b0 || t_req_out !== 1'b0 || t_ovv !== 1'b0) begin errors++; $display("FAIL rmid_during got req_in=%b req_out=%b ovv=%b want 0/0/0", t_req_in, t_req_out, t_ovv); end
      step();
      t_rst = 1; #1;
      checks++; if (t_out !== '0 || t_req_in !== 1'b0 || t_req_out !== 1'b0) begin errors++; $display("FAIL rmid_after got data=%h req_in=%b req_out=%b want 0/0/0", t_out, t_req_in, t_req_out); end
      for (int k = 0; k < 2; k++) begin
         t_rdy = 1; #1;
         checks++; if (t_req_in !== 1'b1) begin errors++; $display("FAIL rmid_read%0d got=%b want=1", k, t_req_in); end
         step();
         t_rdy = 0; t_in = (k == 0) ? Chunk0 : Chunk1; #1;
         step();
         #1;
         checks++; if (t_req_out !== 1'b1 || t_ovv !== (k == 1) || t_out !== ((k == 0) ? Exp0 : Exp1)) begin
            errors++;
            $display("FAIL rmid_write%0d got req_out=%b ovv=%b data=%h want 1/%b/%h", k, t_req_out, t_ovv, t_out, (k == 1), (k == 0) ? Exp0 : Exp1);
         end
         step();
      end
   endtask

   task automatic test_idle();
      int seen;
      seen = 0;
      d_rdy = 0; d_ordy = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (d_req_in !== 1'b0 || d_req_out !== 1'b0) seen++;
         step();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL idle_strobes got=%0d cycles with strobes want=0", seen); end
      d_rdy = 1; #1;
      checks++; if (d_req_in !== 1'b1) begin errors++; $display("FAIL idle_still_read got req_in=%b want=1", d_req_in); end
      step();
      d_rdy = 0;
      step();
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_default();
      test_scale();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
